// File: rtl/eth_speed_detect.sv
// PHY link-speed detector: edge rate of a synchronised rx toggle vs a
// local reference window, with a consecutive-window commit filter.
module eth_speed_detect #(
   parameter int         REF_CNT_WIDTH  = 7,
   parameter int         EDGE_CNT_WIDTH = 2,
   parameter int         THRESH_100M    = 32,
   parameter int         STABLE_COUNT   = 2,
   parameter int         SYNC_STAGES    = 3,
   parameter logic [1:0] RESET_SPEED    = 2'b10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_toggle,
   input  logic       enable,
   output logic [1:0] speed,
   output logic       mii_select,
   output logic       locked,
   output logic       speed_change
);

   localparam int SW = $clog2(STABLE_COUNT + 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_COUNT);
   localparam logic [REF_CNT_WIDTH-1:0] THRESH = REF_CNT_WIDTH'(THRESH_100M);
   localparam logic [1:0] SPD_10   = 2'b00;
   localparam logic [1:0] SPD_100  = 2'b01;
   localparam logic [1:0] SPD_1000 = 2'b10;
   localparam logic [1:0] NO_CLK   = 2'b11;

   logic [SYNC_STAGES-1:0]    sync_q, sync_d;
   logic [REF_CNT_WIDTH-1:0]  ref_q, ref_d;
   logic [EDGE_CNT_WIDTH-1:0] edge_q, edge_d;
   logic [1:0]                cand_q, cand_d;
   logic [SW-1:0]             stab_q, stab_d;
   logic [1:0]                speed_q, speed_d;
   logic                      mii_q, mii_d;
   logic                      lock_q, lock_d;
   logic                      chg_q, chg_d;

   logic                      edge_det;
   logic                      edge_full;
   logic                      ref_full;
   logic                      close;
   logic [1:0]                meas;

   assign edge_det  = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];
   assign edge_full = &edge_q;
   assign ref_full  = &ref_q;

   // Window close and classification from the registered counters
   always_comb begin
      close = 1'b0;
      meas  = NO_CLK;
      if (enable) begin
         if (edge_full) begin
            close = 1'b1;
            meas  = (ref_q >= THRESH) ? SPD_100 : SPD_1000;
         end else if (ref_full) begin
            close = 1'b1;
            meas  = (edge_q != '0) ? SPD_10 : NO_CLK;
         end
      end
   end

   // Next-state: synchroniser, window counters and commit filter
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], rx_toggle};
      ref_d   = '0;
      edge_d  = '0;
      cand_d  = cand_q;
      stab_d  = stab_q;
      speed_d = speed_q;
      mii_d   = mii_q;
      lock_d  = lock_q;
      chg_d   = 1'b0;
      if (enable && !close) begin
         ref_d  = ref_q + REF_CNT_WIDTH'(1);
         edge_d = edge_q + EDGE_CNT_WIDTH'(edge_det);
      end
      if (close) begin
         if (meas == cand_q) begin
            stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + SW'(1);
         end else begin
            cand_d = meas;
            stab_d = SW'(1);
         end
         if (stab_d == STAB_MAX) begin
            if (meas != NO_CLK) begin
               lock_d = 1'b1;
               if (meas != speed_q) begin
                  speed_d = meas;
                  mii_d   = (meas != SPD_1000);
                  chg_d   = 1'b1;
               end
            end else begin
               lock_d = 1'b0;
            end
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         ref_q   <= '0;
         edge_q  <= '0;
         cand_q  <= NO_CLK;
         stab_q  <= '0;
         speed_q <= RESET_SPEED;
         mii_q   <= (RESET_SPEED != SPD_1000);
         lock_q  <= 1'b0;
         chg_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         ref_q   <= ref_d;
         edge_q  <= edge_d;
         cand_q  <= cand_d;
         stab_q  <= stab_d;
         speed_q <= speed_d;
         mii_q   <= mii_d;
         lock_q  <= lock_d;
         chg_q   <= chg_d;
      end
   end

   assign speed        = speed_q;
   assign mii_select   = mii_q;
   assign locked       = lock_q;
   assign speed_change = chg_q;

endmodule

// File: tb/tb_eth_speed_detect.sv
// Directed bench for eth_speed_detect: default instance plus a
// STABLE_COUNT=1 instance sharing the same stimulus.
module tb_eth_speed_detect;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b0;
   logic       en  = 1'b0;
   logic [1:0] spd, spd1;
   logic       mii, mii1;
   logic       lck, lck1;
   logic       chg, chg1;

   int pc  = 0;
   int pc1 = 0;
   int npass = 0;
   int ntot  = 0;
   int p0, p1;
   logic [31:0] sbq[$];

   always #5 clk = ~clk;

   eth_speed_detect dut (
      .clk(clk), .rst(rst), .rx_toggle(rx), .enable(en),
      .speed(spd), .mii_select(mii), .locked(lck), .speed_change(chg)
   );

   eth_speed_detect #(.STABLE_COUNT(1)) dut1 (
      .clk(clk), .rst(rst), .rx_toggle(rx), .enable(en),
      .speed(spd1), .mii_select(mii1), .locked(lck1), .speed_change(chg1)
   );

   // pulse counters, sampled mid-cycle
   always @(negedge clk) begin
      if (chg)  pc  <= pc + 1;
      if (chg1) pc1 <= pc1 + 1;
   end

   task automatic push(input logic [31:0] v);
      sbq.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] ex;
      ntot++;
      if (sbq.size() == 0) begin
         $error("FAIL %s scoreboard empty obs=%0h", tag, obs);
      end else begin
         ex = sbq.pop_front();
         assert (obs === ex) npass++;
         else $error("FAIL %s obs=%0h exp=%0h", tag, obs, ex);
      end
   endtask

   task automatic tog(input int period, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (period > 0 && (i % period) == period - 1) rx = ~rx;
      end
   endtask

   task automatic edges(input int gap, input int n);
      for (int k = 0; k < n; k++) begin
         repeat (gap) @(posedge clk);
         #1 rx = ~rx;
      end
   endtask

   initial begin
      // reset values
      repeat (3) @(posedge clk);
      #1;
      push(2); push(0); push(0); push(0);
      chk("rst_speed", spd);
      chk("rst_mii", mii);
      chk("rst_lock", lck);
      chk("rst_chg", chg);

      // 1000M from reset: lock without pulse
      rst = 1'b0; en = 1'b1;
      p0 = pc;
      push(2); push(0); push(1); push(0);
      tog(4, 100);
      chk("g_speed", spd);
      chk("g_mii", mii);
      chk("g_lock", lck);
      chk("g_pulse", pc - p0);

      // 100M
      p0 = pc;
      push(1); push(1); push(1); push(1);
      tog(20, 600);
      chk("c_speed", spd);
      chk("c_mii", mii);
      chk("c_lock", lck);
      chk("c_pulse", pc - p0);

      // 10M: ref window closes with 1..2 edges
      p0 = pc;
      push(0); push(1); push(1); push(1);
      tog(100, 1200);
      chk("t_speed", spd);
      chk("t_mii", mii);
      chk("t_lock", lck);
      chk("t_pulse", pc - p0);

      // back to 1000M
      p0 = pc;
      push(2); push(1); push(1);
      tog(4, 200);
      chk("g2_speed", spd);
      chk("g2_lock", lck);
      chk("g2_pulse", pc - p0);

      // clock loss: unlock, speed held
      p0 = pc;
      push(2); push(0); push(0);
      tog(0, 400);
      chk("nc_speed", spd);
      chk("nc_lock", lck);
      chk("nc_pulse", pc - p0);

      // clock returns: relock, no pulse
      p0 = pc;
      push(2); push(1); push(0);
      tog(4, 200);
      chk("rl_speed", spd);
      chk("rl_lock", lck);
      chk("rl_pulse", pc - p0);

      // alternating single 100M / 1000M windows from a fresh reset
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      p0 = pc; p1 = pc1;
      for (int g = 0; g < 3; g++) begin
         edges(20, 3);
         edges(4, 3);
      end
      repeat (10) @(posedge clk);
      #1;
      push(2); push(0); push(0); push(6); push(2); push(1);
      chk("alt_speed", spd);
      chk("alt_lock", lck);
      chk("alt_pulse", pc - p0);
      chk("alt1_pulse", pc1 - p1);
      chk("alt1_speed", spd1);
      chk("alt1_lock", lck1);

      // lock at 100M, then reset mid-window
      tog(20, 600);
      push(1);
      chk("pre_rst_speed", spd);
      repeat (7) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      push(2); push(0); push(0); push(0);
      chk("mr_speed", spd);
      chk("mr_mii", mii);
      chk("mr_lock", lck);
      chk("mr_chg", chg);

      // disabled: toggling gives no measurements
      @(posedge clk); #1;
      rst = 1'b0; en = 1'b0;
      p0 = pc;
      push(0); push(2); push(0); push(0);
      tog(4, 500);
      chk("dis_pulse", pc - p0);
      chk("dis_speed", spd);
      chk("dis_lock", lck);
      chk("dis_mii", mii);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
